weight_load_ctrl: RTL and testbench
===================================

# weight_load_ctrl

Sequencer that streams a flat run of weight words into the per-neuron weight memories of one layer at run time, for builds without pretrained weights. It accepts words over a valid/ready handshake and writes them in neuron-major order: neuron 0 addresses 0..numWeights-1, then neuron 1, and so on. It drives the one-hot write enables, shared address and shared data of every neuron weight memory in the layer. It pulses `done` once the final write has landed.

## Interface
- numNeurons, 16, number of neuron weight memories in the layer
- numWeights, 16, words per neuron memory
- addressWidth, 4, weight memory address width; must satisfy 2**addressWidth >= numWeights
- dataWidth, 16, weight word width
- neuronWidth, 4, neuron index width; must satisfy 2**neuronWidth >= numNeurons
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset: asynchronous, active-low
- start  in  1  begin a load; honoured only in IDLE
- abort  in  1  cancel a load in progress
- inValid  in  1  `inData` is valid
- inData  in  dataWidth  weight word
- inReady  out  1  controller accepts a word this cycle
- wrEn  out  numNeurons  one-hot write enable, one bit per neuron memory
- wrAddr  out  addressWidth  write address, shared by all memories
- wrData  out  dataWidth  write data, shared by all memories
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when a load completes
- curNeuron  out  neuronWidth  neuron index of the next word to be accepted
- curAddr  out  addressWidth  address of the next word to be accepted

## Operation
- States:
  - IDLE: inReady=0. On start, go to LOAD and clear curNeuron and curAddr.
  - LOAD: inReady=1. Abort takes priority over the final accept: on abort, go to IDLE. Otherwise, the final accept goes to FLUSH.
  - FLUSH: one cycle, inReady=0. The final write is on the outputs. Go to DONE.
  - DONE: one cycle, done=1. Go to IDLE.
- Accept occurs when inValid && inReady at a rising edge. On accept, register:
  - wrEn = one-hot(curNeuron)
  - wrAddr = curAddr
  - wrData = inData
- wrEn is zero in every cycle that does not directly follow an accept.
- Counter update on accept:
  - If curAddr == numWeights-1: curAddr wraps to 0 and curNeuron increments.
  - Otherwise curAddr increments.
  - The final word is the one accepted at (numNeurons-1, numWeights-1). Counters do not advance past it; they hold until the next start.
- Abort in LOAD:
  - A write already registered from an accept on the preceding edge still completes.
  - The word presented in the abort cycle is not accepted.
  - Counters clear. done is not pulsed.
- Abort in IDLE, FLUSH or DONE is ignored. start outside IDLE is ignored.
- start and abort in the same IDLE cycle: start wins; abort is ignored because the controller is in IDLE.
- inData is not checked. The controller writes every accepted word as presented.

## Timing
- Reset (async assert, sync release): state=IDLE. Every output is 0: inReady, wrEn, wrAddr, wrData, busy, done, curNeuron, curAddr.
- Reset asserted mid-load: all outputs clear immediately. Any partial load is abandoned with no further writes.
- Latency: a word accepted at edge k appears on wrEn/wrAddr/wrData for cycle k..k+1. The memory captures it at edge k+1.
- inReady is a registered function of state only, with no combinational path from inValid. Throughput is one word per cycle.
- start at edge s: inReady=1 from cycle s+1.
- Final accept at edge k:
  - inReady=0 and the final wrEn are in cycle k+1.
  - done=1 in cycle k+2.
  - busy=0 from cycle k+3.
- Minimum load time = numNeurons*numWeights + 3 cycles after start.

## Structure
- Shared package nn_pkg holds:
  - the state enum `loadState_t` {IDLE, LOAD, FLUSH, DONE}
  - the helper width constants used across neuron/layer blocks
- One natural sub-module, weight_addr_counter: a nested wrap counter.
  - Inputs: clear, inc.
  - Outputs: addr, neuron, last.
  - last = (neuron==numNeurons-1 && addr==numWeights-1).
- One-hot decode and the FSM stay in the top module.

## Test plan
Bench overrides numNeurons=4, numWeights=4. It instantiates 4 weight memories, non-pretrained, writes enabled.
- Reset values: assert rst_n=0 mid-cycle, with no clock edge → every output 0 at once. Release, then 3 cycles with no stimulus → outputs stay 0 and busy=0.
- Full load: start, then 16 back-to-back words 0x0100..0x010F → wrEn 0001 for words 0..3, 0010 for words 4..7, and so on. Memory n address a holds 0x0100+4n+a. done pulses exactly once, 2 cycles after the final accept. Total 19 cycles from start to done.
- Backpressure from source: inValid toggles 1,0,0,1,… → writes occur only on accepted words; curAddr/curNeuron advance only on accepts; final contents match the full-load case.
- Abort after 6 accepts, with inValid high in the abort cycle:
  - the 6th write completes (memory 1 address 1 written)
  - no write at memory 1 address 2
  - no done pulse; curNeuron=0, curAddr=0
  - a following start reloads from (0,0)
- start pulsed during LOAD and during DONE → ignored; counters and sequence are unaffected.
- Reset mid-load after 9 accepts → outputs clear immediately and no further wrEn. A fresh start after release loads from (0,0).

Source files
------------

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types and width constants for neuron/layer blocks
package nn_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} loadState_t;

  localparam int NN_NUM_NEURONS = 16;
  localparam int NN_NUM_WEIGHTS = 16;
  localparam int NN_ADDR_W      = 4;
  localparam int NN_DATA_W      = 16;
  localparam int NN_NEURON_W    = 4;

endpackage

// File: rtl/weight_addr_counter.sv
// rtl/weight_addr_counter.sv - nested (neuron, address) wrap counter for weight loading
module weight_addr_counter
  import nn_pkg::*;
#(
  parameter int numNeurons   = NN_NUM_NEURONS,
  parameter int numWeights   = NN_NUM_WEIGHTS,
  parameter int addressWidth = NN_ADDR_W,
  parameter int neuronWidth  = NN_NEURON_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    inc,
  output logic [addressWidth-1:0] addr,
  output logic [neuronWidth-1:0]  neuron,
  output logic                    last
);

  localparam logic [addressWidth-1:0] ADDR_MAX   = addressWidth'(numWeights - 1);
  localparam logic [neuronWidth-1:0]  NEURON_MAX = neuronWidth'(numNeurons - 1);

  assign last = (neuron == NEURON_MAX) && (addr == ADDR_MAX);

  // Holds at the final position so the last word's coordinates stay visible until the next clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr   <= '0;
      neuron <= '0;
    end else if (clear) begin
      addr   <= '0;
      neuron <= '0;
    end else if (inc && !last) begin
      if (addr == ADDR_MAX) begin
        addr   <= '0;
        neuron <= neuron + neuronWidth'(1);
      end else begin
        addr <= addr + addressWidth'(1);
      end
    end
  end

endmodule

// File: rtl/weight_load_ctrl.sv
// rtl/weight_load_ctrl.sv - streams a flat run of weight words into per-neuron weight memories
module weight_load_ctrl
  import nn_pkg::*;
#(
  parameter int numNeurons   = NN_NUM_NEURONS,
  parameter int numWeights   = NN_NUM_WEIGHTS,
  parameter int addressWidth = NN_ADDR_W,
  parameter int dataWidth    = NN_DATA_W,
  parameter int neuronWidth  = NN_NEURON_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    inValid,
  input  logic [dataWidth-1:0]    inData,
  output logic                    inReady,
  output logic [numNeurons-1:0]   wrEn,
  output logic [addressWidth-1:0] wrAddr,
  output logic [dataWidth-1:0]    wrData,
  output logic                    busy,
  output logic                    done,
  output logic [neuronWidth-1:0]  curNeuron,
  output logic [addressWidth-1:0] curAddr
);

  loadState_t state, next_state;
  logic       accept;
  logic       last;
  logic       clear;

  // The abort-cycle word is refused, so abort gates the handshake itself.
  assign accept = inValid && inReady && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    clear      = 1'b0;
    inReady    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          next_state = LOAD;
          clear      = 1'b1;
        end
      end
      LOAD: begin
        inReady = 1'b1;
        if (abort) begin
          next_state = IDLE;
          clear      = 1'b1;
        end else if (accept && last) begin
          next_state = FLUSH;
        end
      end
      FLUSH:   next_state = DONE;
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  weight_addr_counter #(
    .numNeurons  (numNeurons),
    .numWeights  (numWeights),
    .addressWidth(addressWidth),
    .neuronWidth (neuronWidth)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .inc   (accept),
    .addr  (curAddr),
    .neuron(curNeuron),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrEn   <= '0;
      wrAddr <= '0;
      wrData <= '0;
    end else begin
      wrEn <= accept ? (numNeurons'(1) << curNeuron) : '0;
      if (accept) begin
        wrAddr <= curAddr;
        wrData <= inData;
      end
    end
  end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb/tb_weight_load_ctrl.sv - scoreboard bench for weight_load_ctrl on a 4x4 layer
module tb_weight_load_ctrl;

  localparam int NN = 4;
  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        inValid = 1'b0;
  logic [15:0] inData = '0;
  logic        inReady;
  logic [3:0]  wrEn;
  logic [3:0]  wrAddr;
  logic [15:0] wrData;
  logic        busy;
  logic        done;
  logic [3:0]  curNeuron;
  logic [3:0]  curAddr;

  typedef struct packed {
    logic [3:0]  en;
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_drv = 0;
  int last_acc = 0;

  logic        mem_clr = 1'b0;
  logic [15:0] mem   [NN][16];
  logic        wflag [NN][16];

  weight_load_ctrl #(
    .numNeurons(NN),
    .numWeights(NW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .inValid  (inValid),
    .inData   (inData),
    .inReady  (inReady),
    .wrEn     (wrEn),
    .wrAddr   (wrAddr),
    .wrData   (wrData),
    .busy     (busy),
    .done     (done),
    .curNeuron(curNeuron),
    .curAddr  (curAddr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Four neuron weight memories sharing address and data.
  always @(posedge clk) begin
    for (int n = 0; n < NN; n++) begin
      for (int a = 0; a < 16; a++) begin
        if (mem_clr) wflag[n][a] <= 1'b0;
      end
      if (!mem_clr && wrEn[n]) begin
        mem[n][wrAddr]   <= wrData;
        wflag[n][wrAddr] <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (wrEn != 4'b0000) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: actual wrEn=%b addr=%0d data=0x%0h required=no write", wrEn, wrAddr, wrData);
        end else begin
          mon_e = sb.pop_front();
          chk("write_en", 32'(wrEn), 32'(mon_e.en));
          chk("write_addr", 32'(wrAddr), 32'(mon_e.addr));
          chk("write_data", 32'(wrData), 32'(mon_e.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] wv(input int n, input int a);
    return 16'(16'h0100 + 4 * n + a);
  endfunction

  task automatic clear_mem();
    mem_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_inReady"}, 32'(inReady), 0);
    chk({tag, "_wrEn"}, 32'(wrEn), 0);
    chk({tag, "_wrAddr"}, 32'(wrAddr), 0);
    chk({tag, "_wrData"}, 32'(wrData), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_curNeuron"}, 32'(curNeuron), 0);
    chk({tag, "_curAddr"}, 32'(curAddr), 0);
  endtask

  task automatic send(input int n, input int a, input bit v, input bit ab, input bit st);
    wr_t e;
    inValid = v;
    abort   = ab;
    start   = st;
    inData  = v ? wv(n, a) : 16'hDEAD;
    if (v && !ab) begin
      e.en   = 4'(1 << n);
      e.addr = 4'(a);
      e.data = wv(n, a);
      sb.push_back(e);
    end
    tick();
    if (v && !ab) last_acc = cyc;
    inValid = 1'b0;
    abort   = 1'b0;
    start   = 1'b0;
    inData  = '0;
  endtask

  task automatic full_load(input bit gaps, input bit noise);
    int idx;
    int slot;
    int d0;
    bit v;
    idx  = 0;
    slot = 0;
    d0   = done_cnt;
    start_drv = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ready_after_start", 32'(inReady), 1);
    chk("busy_after_start", 32'(busy), 1);
    chk("neuron_after_start", 32'(curNeuron), 0);
    chk("addr_after_start", 32'(curAddr), 0);
    while (idx < NN * NW) begin
      v = !gaps || (slot % 3 == 0);
      send(idx / NW, idx % NW, v, 1'b0, noise && idx == 5);
      if (v) idx++;
      slot++;
      chk("cur_neuron", 32'(curNeuron), (idx < NN * NW) ? idx / NW : NN - 1);
      chk("cur_addr", 32'(curAddr), (idx < NN * NW) ? idx % NW : NW - 1);
    end
    chk("ready_in_flush", 32'(inReady), 0);
    chk("busy_in_flush", 32'(busy), 1);
    chk("done_in_flush", 32'(done), 0);
    tick();
    chk("done_pulse", 32'(done), 1);
    start = noise;
    tick();
    start = 1'b0;
    chk("busy_after_done", 32'(busy), 0);
    chk("done_after_pulse", 32'(done), 0);
    chk("hold_neuron", 32'(curNeuron), NN - 1);
    chk("hold_addr", 32'(curAddr), NW - 1);
    tick();
    chk("still_idle", 32'(busy), 0);
    chk("done_count", done_cnt - d0, 1);
    chk("done_after_final", done_cyc, last_acc + 1);
    if (!gaps) chk("start_to_done_cycles", done_cyc - start_drv + 1, NN * NW + 3);
    for (int n = 0; n < NN; n++) begin
      for (int a = 0; a < NW; a++) begin
        chk("mem_written", 32'(wflag[n][a]), 1);
        chk("mem_value", 32'(mem[n][a]), 32'(wv(n, a)));
      end
    end
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    int d0;
    int cnt;

    #2 rst_n = 1'b0;
    #1 check_zero("reset_async");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      check_zero("post_reset");
    end

    clear_mem();
    full_load(1'b0, 1'b0);

    clear_mem();
    full_load(1'b1, 1'b0);

    // Abort after six accepts with a valid word presented in the abort cycle.
    clear_mem();
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) send(i / NW, i % NW, 1'b1, 1'b0, 1'b0);
    send(1, 2, 1'b1, 1'b1, 1'b0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(inReady), 0);
    chk("abort_neuron", 32'(curNeuron), 0);
    chk("abort_addr", 32'(curAddr), 0);
    repeat (3) tick();
    chk("abort_last_write_flag", 32'(wflag[1][1]), 1);
    chk("abort_last_write_value", 32'(mem[1][1]), 32'h0105);
    chk("abort_refused_word", 32'(wflag[1][2]), 0);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_drained", sb.size(), 0);
    full_load(1'b0, 1'b0);

    clear_mem();
    full_load(1'b0, 1'b1);

    // Reset lands after the 9th accept but before its capture edge, so 8 words reach memory.
    clear_mem();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) send(i / NW, i % NW, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero("reset_mid_load");
    repeat (3) begin
      tick();
      chk("reset_hold_wrEn", 32'(wrEn), 0);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    chk("reset_idle_busy", 32'(busy), 0);
    cnt = 0;
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < NW; a++)
        if (wflag[n][a]) cnt++;
    chk("writes_before_reset", cnt, 8);
    chk("ninth_word_dropped", 32'(wflag[2][0]), 0);
    chk("reset_drained", sb.size(), 0);
    full_load(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
